// File: rtl/decode_stage.sv
// Instruction-decode stage: IF/ID capture, field split, 16-entry register file,
// load-use hazard detection and a registered ID/EX boundary. Macro: DECODE_WB_BYPASS_EN.
module decode_stage #(
  parameter int DATA_WIDTH = 27,
  parameter int REG_COUNT  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] i_Pc,
  input  logic [DATA_WIDTH-1:0] i_Instruction,
  input  logic                  i_Flush,
  input  logic                  i_EX_Mem_Read,
  input  logic [3:0]            i_EX_Dest,
  input  logic                  i_WB_En,
  input  logic [3:0]            i_WB_Dest,
  input  logic [DATA_WIDTH-1:0] i_WB_Data,
  output logic                  o_Freeze,
  output logic                  o_Valid,
  output logic [DATA_WIDTH-1:0] o_Pc,
  output logic [4:0]            o_Opcode,
  output logic [3:0]            o_Rd,
  output logic [DATA_WIDTH-1:0] o_Rs1_Data,
  output logic [DATA_WIDTH-1:0] o_Rs2_Data,
  output logic [DATA_WIDTH-1:0] o_Imm
);

  logic                  if_valid;
  logic [DATA_WIDTH-1:0] if_pc;
  logic [DATA_WIDTH-1:0] if_instr;
  logic [DATA_WIDTH-1:0] rf [REG_COUNT];

  logic [4:0]            opcode;
  logic [3:0]            rd;
  logic [3:0]            rs1;
  logic [3:0]            rs2;
  logic                  imm_form;
  logic [DATA_WIDTH-1:0] imm_ext;
  logic [DATA_WIDTH-1:0] rs1_val;
  logic [DATA_WIDTH-1:0] rs2_val;

  assign opcode   = if_instr[26:22];
  assign rd       = if_instr[21:18];
  assign rs1      = if_instr[17:14];
  assign rs2      = if_instr[13:10];
  assign imm_form = opcode[4];
  assign imm_ext  = {{(DATA_WIDTH-14){if_instr[13]}}, if_instr[13:0]};

  // Fetch contract: o_Freeze is valid within the cycle and Fetch must hold its
  // PC/instruction across the following edge; i_Flush overrides any freeze.
  assign o_Freeze = if_valid & i_EX_Mem_Read & (i_EX_Dest != 4'd0) &
                    ((i_EX_Dest == rs1) | (!imm_form & (i_EX_Dest == rs2)));

  always_comb begin
    rs1_val = rf[rs1];
    rs2_val = rf[rs2];
`ifdef DECODE_WB_BYPASS_EN
    if (i_WB_En && (i_WB_Dest == rs1)) rs1_val = i_WB_Data;
    if (i_WB_En && (i_WB_Dest == rs2)) rs2_val = i_WB_Data;
`endif
    if (rs1 == 4'd0) rs1_val = '0;
    if ((rs2 == 4'd0) || imm_form) rs2_val = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) rf[i] <= '0;
    end else if (i_WB_En && (i_WB_Dest != 4'd0)) begin
      rf[i_WB_Dest] <= i_WB_Data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_instr <= '0;
    end else if (i_Flush) begin
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_instr <= '0;
    end else if (!o_Freeze) begin
      if_valid <= 1'b1;
      if_pc    <= i_Pc;
      if_instr <= i_Instruction;
    end
  end

  // Bubbles and squashed slots are stored as all-zero so invalid outputs read 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_Valid    <= 1'b0;
      o_Pc       <= '0;
      o_Opcode   <= '0;
      o_Rd       <= '0;
      o_Rs1_Data <= '0;
      o_Rs2_Data <= '0;
      o_Imm      <= '0;
    end else if (i_Flush || o_Freeze || !if_valid) begin
      o_Valid    <= 1'b0;
      o_Pc       <= '0;
      o_Opcode   <= '0;
      o_Rd       <= '0;
      o_Rs1_Data <= '0;
      o_Rs2_Data <= '0;
      o_Imm      <= '0;
    end else begin
      o_Valid    <= 1'b1;
      o_Pc       <= if_pc;
      o_Opcode   <= opcode;
      o_Rd       <= rd;
      o_Rs1_Data <= rs1_val;
      o_Rs2_Data <= rs2_val;
      o_Imm      <= imm_ext;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed vector bench for decode_stage; expected values are hand-computed per row.
module tb_decode_stage;

  localparam int DW = 27;
`ifdef DECODE_WB_BYPASS_EN
  localparam logic [DW-1:0] BYP = 27'd123;
`else
  localparam logic [DW-1:0] BYP = 27'd0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] i_Pc = '0, i_Instruction = '0, i_WB_Data = '0;
  logic          i_Flush = 1'b0, i_EX_Mem_Read = 1'b0, i_WB_En = 1'b0;
  logic [3:0]    i_EX_Dest = '0, i_WB_Dest = '0;
  logic          o_Freeze, o_Valid;
  logic [DW-1:0] o_Pc, o_Rs1_Data, o_Rs2_Data, o_Imm;
  logic [4:0]    o_Opcode;
  logic [3:0]    o_Rd;

  decode_stage dut (
    .clk(clk), .reset(reset), .i_Pc(i_Pc), .i_Instruction(i_Instruction),
    .i_Flush(i_Flush), .i_EX_Mem_Read(i_EX_Mem_Read), .i_EX_Dest(i_EX_Dest),
    .i_WB_En(i_WB_En), .i_WB_Dest(i_WB_Dest), .i_WB_Data(i_WB_Data),
    .o_Freeze(o_Freeze), .o_Valid(o_Valid), .o_Pc(o_Pc), .o_Opcode(o_Opcode),
    .o_Rd(o_Rd), .o_Rs1_Data(o_Rs1_Data), .o_Rs2_Data(o_Rs2_Data), .o_Imm(o_Imm)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] pc;
    logic [4:0]    op;
    logic [3:0]    rd;
    logic [DW-1:0] rs1;
    logic [DW-1:0] rs2;
    logic [DW-1:0] imm;
  } out_t;

  typedef struct {
    logic [DW-1:0] pc, instr;
    logic          flush, mrd;
    logic [3:0]    exd;
    logic          we;
    logic [3:0]    wd;
    logic [DW-1:0] wdat;
    logic          frz;
    out_t          exp;
  } vec_t;

  vec_t vecs[16];
  logic [$bits(out_t)-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [DW-1:0] ins(input logic [4:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [13:0] low);
    return {op, rd, rs1, low};
  endfunction

  function automatic vec_t mk(input logic [DW-1:0] pc, instr, input logic fl, mr,
                              input logic [3:0] exd, input logic we, input logic [3:0] wd,
                              input logic [DW-1:0] wdat, input logic frz, input logic v,
                              input logic [DW-1:0] opc, input logic [4:0] op,
                              input logic [3:0] rd, input logic [DW-1:0] r1, r2, im);
    vec_t t;
    t.pc = pc; t.instr = instr; t.flush = fl; t.mrd = mr; t.exd = exd;
    t.we = we; t.wd = wd; t.wdat = wdat; t.frz = frz;
    t.exp = '{valid: v, pc: opc, op: op, rd: rd, rs1: r1, rs2: r2, imm: im};
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input out_t e);
    chk({tag, " valid"}, {31'd0, o_Valid}, {31'd0, e.valid});
    chk({tag, " pc"}, {5'd0, o_Pc}, {5'd0, e.pc});
    chk({tag, " opcode"}, {27'd0, o_Opcode}, {27'd0, e.op});
    chk({tag, " rd"}, {28'd0, o_Rd}, {28'd0, e.rd});
    chk({tag, " rs1_data"}, {5'd0, o_Rs1_Data}, {5'd0, e.rs1});
    chk({tag, " rs2_data"}, {5'd0, o_Rs2_Data}, {5'd0, e.rs2});
    chk({tag, " imm"}, {5'd0, o_Imm}, {5'd0, e.imm});
  endtask

  task automatic drive(input vec_t t);
    i_Pc = t.pc; i_Instruction = t.instr; i_Flush = t.flush;
    i_EX_Mem_Read = t.mrd; i_EX_Dest = t.exd;
    i_WB_En = t.we; i_WB_Dest = t.wd; i_WB_Data = t.wdat;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    out_t e;
    vecs[0]  = mk(0,  ins(0, 1, 0, 0),          0, 0, 0, 1, 3, 27'h0ABCDEF, 0, 0, 0,  0,     0,  0,           0,           0);
    vecs[1]  = mk(4,  ins(2, 2, 3, 0),          0, 0, 0, 1, 0, 5,           0, 1, 0,  0,     1,  0,           0,           0);
    vecs[2]  = mk(8,  ins(3, 5, 0, 0),          0, 0, 0, 0, 0, 0,           0, 1, 4,  2,     2,  27'h0ABCDEF, 0,           0);
    vecs[3]  = mk(12, ins(4, 6, 4, 14'h0C00),   0, 1, 4, 1, 4, 27'h111,     0, 1, 8,  3,     5,  0,           0,           0);
    vecs[4]  = mk(16, ins(1, 7, 3, 0),          0, 1, 4, 0, 0, 0,           1, 0, 0,  0,     0,  0,           0,           0);
    vecs[5]  = mk(16, ins(1, 7, 3, 0),          0, 0, 0, 0, 0, 0,           0, 1, 12, 4,     6,  27'h111,     27'h0ABCDEF, 27'h0C00);
    vecs[6]  = mk(20, ins(5'h11, 8, 2, 14'h1000), 0, 1, 0, 0, 0, 0,         0, 1, 16, 1,     7,  27'h0ABCDEF, 0,           0);
    vecs[7]  = mk(24, ins(5'h11, 9, 5, 14'h2000), 0, 1, 4, 0, 0, 0,         0, 1, 20, 5'h11, 8,  0,           0,           27'h1000);
    vecs[8]  = mk(28, ins(6, 10, 5, 0),         0, 0, 0, 0, 0, 0,           0, 1, 24, 5'h11, 9,  0,           0,           27'h7FFE000);
    vecs[9]  = mk(32, ins(7, 1, 1, 0),          1, 1, 5, 0, 0, 0,           1, 0, 0,  0,     0,  0,           0,           0);
    vecs[10] = mk(20, ins(2, 11, 3, 0),         0, 0, 0, 0, 0, 0,           0, 0, 0,  0,     0,  0,           0,           0);
    vecs[11] = mk(24, ins(0, 0, 0, 0),          0, 0, 0, 0, 0, 0,           0, 1, 20, 2,     11, 27'h0ABCDEF, 0,           0);
    vecs[12] = mk(28, ins(3, 12, 7, 14'h1C00),  0, 0, 0, 0, 0, 0,           0, 1, 24, 0,     0,  0,           0,           0);
    vecs[13] = mk(32, ins(0, 0, 0, 0),          0, 0, 0, 1, 7, 27'd123,     0, 1, 28, 3,     12, BYP,         BYP,         27'h1C00);
    vecs[14] = mk(36, ins(1, 1, 7, 0),          0, 0, 0, 0, 0, 0,           0, 1, 32, 0,     0,  0,           0,           0);
    vecs[15] = mk(40, ins(0, 0, 0, 0),          0, 0, 0, 0, 0, 0,           0, 1, 36, 1,     1,  27'd123,     0,           0);

    // Reset held low with random activity on every input.
    for (int k = 0; k < 2; k++) begin
      i_Pc = DW'($urandom); i_Instruction = DW'($urandom);
      i_Flush = 1'($urandom_range(0, 1)); i_EX_Mem_Read = 1'b1;
      i_EX_Dest = 4'($urandom_range(1, 15)); i_WB_En = 1'b1;
      i_WB_Dest = 4'($urandom_range(1, 15)); i_WB_Data = DW'($urandom);
      tick();
      chk($sformatf("reset%0d freeze", k), {31'd0, o_Freeze}, 32'd0);
      chk_out($sformatf("reset%0d", k), '0);
    end
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;

    for (int r = 0; r < 16; r++) begin
      drive(vecs[r]);
      exp_q.push_back(vecs[r].exp);
      #2;
      chk($sformatf("row%0d freeze", r), {31'd0, o_Freeze}, {31'd0, vecs[r].frz});
      tick();
      e = out_t'(exp_q.pop_front());
      chk_out($sformatf("row%0d", r), e);
    end

    // Register-form rs2 load-use hazard.
    drive(mk(44, ins(2, 1, 0, 14'h2400), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    i_EX_Mem_Read = 1'b1; i_EX_Dest = 4'd9;
    #1;
    chk("rs2 hazard freeze", {31'd0, o_Freeze}, 32'd1);

    // Reset asserted while frozen clears everything, including the register file.
    reset = 1'b0;
    #1;
    chk("midreset freeze", {31'd0, o_Freeze}, 32'd0);
    chk_out("midreset", '0);
    drive(mk(200, ins(1, 3, 3, 0), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    reset = 1'b1;
    #2;
    chk("post reset freeze", {31'd0, o_Freeze}, 32'd0);
    tick();
    tick();
    chk_out("post reset issue", '{valid: 1'b1, pc: 27'd200, op: 5'd1, rd: 4'd3,
                                   rs1: '0, rs2: '0, imm: '0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
